cpu_front_fde: RTL and testbench

- Fetch, decode and execute front end of the 5-stage TinyCPU pipeline.
- Owns the PC, the issue (fetch) stage, the decode stage with its 32x32 register file, and the execute-stage ALU register.
- Feeds the memory stage.
- Receives the write-back port and the external stall from the hazard detector.

---
 rtl/cpu_arch_pkg.sv | 39 +++
 rtl/cpu_regfile.sv | 32 +++
 rtl/cpu_front_fde.sv | 131 +++++++++++++
 tb/tb_cpu_front_fde.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_arch_pkg.sv
// TinyCPU architectural constants: instruction type codes, field positions and reset values.
// Shared by the front end and its register file.
package cpu_arch_pkg;

  localparam logic [4:0] T_NOP   = 5'd0;
  localparam logic [4:0] T_HALT  = 5'd1;
  localparam logic [4:0] T_LOADI = 5'd2;
  localparam logic [4:0] T_LOAD  = 5'd3;
  localparam logic [4:0] T_STORE = 5'd4;
  localparam logic [4:0] T_JUMP  = 5'd5;
  localparam logic [4:0] T_ADD   = 5'd6;
  localparam logic [4:0] T_SUB   = 5'd7;
  localparam logic [4:0] T_AND   = 5'd8;
  localparam logic [4:0] T_OR    = 5'd9;
  localparam logic [4:0] T_XOR   = 5'd10;
  localparam logic [4:0] T_SLL   = 5'd11;

  localparam int TYPE_LSB = 27;
  localparam int A_LSB    = 22;
  localparam int B_LSB    = 17;
  localparam int D_LSB    = 12;
  localparam int IMM_W    = 22;

  localparam logic [31:0] NOP_WORD     = 32'd0;
  localparam logic [31:0] RESET_PC_DEF = 32'd0;

  function automatic logic [4:0] f_type(input logic [31:0] instr);
    return instr[TYPE_LSB +: 5];
  endfunction

  function automatic logic [4:0] f_ra(input logic [31:0] instr);
    return instr[A_LSB +: 5];
  endfunction

  function automatic logic [4:0] f_rb(input logic [31:0] instr);
    return instr[B_LSB +: 5];
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
// A read of the register being written this cycle returns the incoming write data.
module cpu_regfile
  import cpu_arch_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr_a,
  input  logic [4:0]  i_raddr_b,
  output logic [31:0] o_rdata_a,
  output logic [31:0] o_rdata_b
);

  logic [31:0] r_mem [NREGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_we && (i_waddr == i_raddr_a)) ? i_wdata : r_mem[i_raddr_a];
  assign o_rdata_b = (i_we && (i_waddr == i_raddr_b)) ? i_wdata : r_mem[i_raddr_b];

endmodule

// File: rtl/cpu_front_fde.sv
// TinyCPU fetch/decode/execute front end: PC, issue, decode with register file, execute ALU.
// Optional CPU_DEBUG_PROBES_EN adds pc_dbg/instr_type_dbg outputs and a per-cycle trace.
module cpu_front_fde
  import cpu_arch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] imem_rdata,
  input  logic        wb_en,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic [31:0] pc,
  output logic [31:0] issue_instr,
  output logic [31:0] decode_ireg,
  output logic [31:0] exe_ireg,
  output logic [31:0] alu_result,
  output logic [31:0] op_a_exe,
  output logic [31:0] op_b_exe,
  output logic        squash
`ifdef CPU_DEBUG_PROBES_EN
  ,
  output logic [31:0] pc_dbg,
  output logic [4:0]  instr_type_dbg
`endif
);

  logic [31:0] r_pc;
  logic [31:0] r_dec_ireg;
  logic [31:0] r_op_a_dec;
  logic [31:0] r_op_b_dec;
  logic [31:0] r_exe_ireg;
  logic [31:0] r_op_a_exe;
  logic [31:0] r_op_b_exe;
  logic [31:0] r_alu;

  logic [31:0] w_rd_a;
  logic [31:0] w_rd_b;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_alu_nxt;
  logic        w_squash;
  logic        w_issue_halt;

  assign issue_instr  = imem_rdata;
  assign w_issue_halt = (f_type(imem_rdata) == T_HALT);
  assign w_squash     = (f_type(r_dec_ireg) == T_JUMP) && (r_op_a_dec != 32'd0);

  cpu_regfile #(
    .NREGS (NREGS)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_we      (wb_en),
    .i_waddr   (wb_reg),
    .i_wdata   (wb_data),
    .i_raddr_a (f_ra(imem_rdata)),
    .i_raddr_b (f_rb(imem_rdata)),
    .o_rdata_a (w_rd_a),
    .o_rdata_b (w_rd_b)
  );

  // A taken jump overrides stall and HALT: the jump target must win.
  always_comb begin
    w_pc_nxt = r_pc + 32'd1;
    if (w_squash)          w_pc_nxt = r_op_b_dec;
    else if (stall)        w_pc_nxt = r_pc;
    else if (w_issue_halt) w_pc_nxt = r_pc;
  end

  always_comb begin
    w_alu_nxt = 32'd0;
    case (f_type(r_dec_ireg))
      T_ADD:   w_alu_nxt = r_op_a_dec + r_op_b_dec;
      T_SUB:   w_alu_nxt = r_op_a_dec - r_op_b_dec;
      T_AND:   w_alu_nxt = r_op_a_dec & r_op_b_dec;
      T_OR:    w_alu_nxt = r_op_a_dec | r_op_b_dec;
      T_XOR:   w_alu_nxt = r_op_a_dec ^ r_op_b_dec;
      T_SLL:   w_alu_nxt = r_op_a_dec << r_op_b_dec[4:0];
      T_LOADI: w_alu_nxt = {{(32 - IMM_W){1'b0}}, r_dec_ireg[IMM_W-1:0]};
      default: w_alu_nxt = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_dec_ireg <= NOP_WORD;
      r_op_a_dec <= '0;
      r_op_b_dec <= '0;
      r_exe_ireg <= NOP_WORD;
      r_op_a_exe <= '0;
      r_op_b_exe <= '0;
      r_alu      <= '0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_dec_ireg <= (w_squash || stall) ? NOP_WORD : imem_rdata;
      r_op_a_dec <= w_rd_a;
      r_op_b_dec <= w_rd_b;
      r_exe_ireg <= r_dec_ireg;
      r_op_a_exe <= r_op_a_dec;
      r_op_b_exe <= r_op_b_dec;
      r_alu      <= w_alu_nxt;
    end
  end

  assign pc          = r_pc;
  assign decode_ireg = r_dec_ireg;
  assign exe_ireg    = r_exe_ireg;
  assign alu_result  = r_alu;
  assign op_a_exe    = r_op_a_exe;
  assign op_b_exe    = r_op_b_exe;
  assign squash      = w_squash;

`ifdef CPU_DEBUG_PROBES_EN
  assign pc_dbg         = r_pc;
  assign instr_type_dbg = f_type(imem_rdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      $display("[fde] pc=%08h issue=%08h dec=%08h exe=%08h stall=%0b squash=%0b",
               r_pc, imem_rdata, r_dec_ireg, r_exe_ireg, stall, w_squash);
    end
  end
`else
  // Probe ports and trace are compiled out.
`endif

endmodule

// File: tb/tb_cpu_front_fde.sv
// Directed bench for cpu_front_fde: reset, LOADI/ADD, bypass, arithmetic edges,
// stall, taken/not-taken jump and HALT, all against hand-computed values.
module tb_cpu_front_fde;

  localparam logic [4:0] OP_HALT  = 5'd1;
  localparam logic [4:0] OP_STORE = 5'd4;
  localparam logic [4:0] OP_JUMP  = 5'd5;
  localparam logic [4:0] OP_ADD   = 5'd6;
  localparam logic [4:0] OP_SUB   = 5'd7;
  localparam logic [4:0] OP_OR    = 5'd9;
  localparam logic [4:0] OP_XOR   = 5'd10;
  localparam logic [4:0] OP_SLL   = 5'd11;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [31:0] imem_rdata;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [31:0] pc;
  logic [31:0] issue_instr;
  logic [31:0] decode_ireg;
  logic [31:0] exe_ireg;
  logic [31:0] alu_result;
  logic [31:0] op_a_exe;
  logic [31:0] op_b_exe;
  logic        squash;
`ifdef CPU_DEBUG_PROBES_EN
  logic [31:0] pc_dbg;
  logic [4:0]  instr_type_dbg;
`endif

  logic [31:0] imem [128];
  int n_checks;
  int n_fail;

  assign imem_rdata = (pc < 32'd128) ? imem[pc[6:0]] : 32'd0;

  cpu_front_fde #(
    .RESET_PC (32'd0),
    .NREGS    (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .imem_rdata  (imem_rdata),
    .wb_en       (wb_en),
    .wb_reg      (wb_reg),
    .wb_data     (wb_data),
    .pc          (pc),
    .issue_instr (issue_instr),
    .decode_ireg (decode_ireg),
    .exe_ireg    (exe_ireg),
    .alu_result  (alu_result),
    .op_a_exe    (op_a_exe),
    .op_b_exe    (op_b_exe),
    .squash      (squash)
`ifdef CPU_DEBUG_PROBES_EN
    ,
    .pc_dbg         (pc_dbg),
    .instr_type_dbg (instr_type_dbg)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [4:0] t, input logic [4:0] a,
                                     input logic [4:0] b, input logic [4:0] d);
    return {t, a, b, d, 12'd0};
  endfunction

  function automatic logic [31:0] mk_li(input logic [4:0] d, input logic [21:0] imm);
    return {5'd2, d, imm};
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 128; i++) imem[i] = 32'd0;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] r, input logic [31:0] d);
    wb_en   = en;
    wb_reg  = r;
    wb_data = d;
  endtask

  // Asserts reset between clock edges and checks the pipeline cleared without a clock.
  task automatic do_reset();
    stall = 1'b0;
    set_wb(1'b0, 5'd0, 32'd0);
    rst = 1'b0;
    #2;
    chk_eq("rst_pc", pc, 32'd0);
    chk_eq("rst_dec", decode_ireg, 32'd0);
    chk_eq("rst_exe", exe_ireg, 32'd0);
    chk_eq("rst_alu", alu_result, 32'd0);
    chk_eq("rst_opa", op_a_exe, 32'd0);
    chk_eq("rst_opb", op_b_exe, 32'd0);
    chk_eq("rst_squash", {31'd0, squash}, 32'd0);
    rst = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    stall    = 1'b0;
    set_wb(1'b0, 5'd0, 32'd0);
    clear_imem();
    step();
    do_reset();

    // LOADI r1,5 ; LOADI r2,7 ; ADD r1,r2 at pc 4
    clear_imem();
    imem[0] = mk_li(5'd1, 22'd5);
    imem[1] = mk_li(5'd2, 22'd7);
    imem[4] = mk(OP_ADD, 5'd1, 5'd2, 5'd3);
    step();
    chk_eq("li_dec", decode_ireg, imem[0]);
    step();
    chk_eq("li1_alu", alu_result, 32'd5);
    chk_eq("li1_exe", exe_ireg, imem[0]);
    set_wb(1'b1, 5'd1, 32'd5);
    step();
    chk_eq("li2_alu", alu_result, 32'd7);
    set_wb(1'b1, 5'd2, 32'd7);
    step();
    set_wb(1'b0, 5'd0, 32'd0);
    chk_eq("add_pc", pc, 32'd4);
    step();
    chk_eq("add_dec", decode_ireg, imem[4]);
    step();
    chk_eq("add_alu", alu_result, 32'd12);
    chk_eq("add_opa", op_a_exe, 32'd5);
    chk_eq("add_opb", op_b_exe, 32'd7);

    // Arithmetic edges plus write-through bypass
    do_reset();
    clear_imem();
    imem[0] = mk(OP_SUB, 5'd0, 5'd5, 5'd0);
    imem[1] = mk(OP_SLL, 5'd5, 5'd6, 5'd0);
    imem[2] = mk(OP_XOR, 5'd5, 5'd6, 5'd0);
    imem[3] = mk(OP_OR,  5'd5, 5'd6, 5'd0);
    imem[4] = mk(OP_STORE, 5'd3, 5'd5, 5'd0);
    set_wb(1'b1, 5'd5, 32'd1);
    step();
    set_wb(1'b1, 5'd6, 32'd31);
    step();
    set_wb(1'b0, 5'd0, 32'd0);
    chk_eq("sub_wrap", alu_result, 32'hFFFF_FFFF);
    step();
    chk_eq("sll_31", alu_result, 32'h8000_0000);
    step();
    chk_eq("xor", alu_result, 32'h0000_001E);
    set_wb(1'b1, 5'd3, 32'h0000_DEAD);
    step();
    set_wb(1'b0, 5'd0, 32'd0);
    chk_eq("or", alu_result, 32'h0000_001F);
    step();
    chk_eq("byp_opa", op_a_exe, 32'h0000_DEAD);
    chk_eq("store_opb", op_b_exe, 32'd1);
    chk_eq("store_alu", alu_result, 32'd0);

    // Stall for two cycles
    do_reset();
    clear_imem();
    for (int i = 0; i < 6; i++) imem[i] = mk_li(5'd0, 22'h100 + 22'(i));
    step();
    chk_eq("stl_pc0", pc, 32'd1);
    stall = 1'b1;
    step();
    chk_eq("stl_pc1", pc, 32'd1);
    chk_eq("stl_dec1", decode_ireg, 32'd0);
    chk_eq("stl_alu", alu_result, 32'h100);
    step();
    chk_eq("stl_pc2", pc, 32'd1);
    chk_eq("stl_dec2", decode_ireg, 32'd0);
    stall = 1'b0;
    step();
    chk_eq("stl_rel_pc", pc, 32'd2);
    chk_eq("stl_rel_dec", decode_ireg, imem[1]);
    step();
    chk_eq("stl_rel_alu", alu_result, 32'h101);

    // Taken jump at pc 4 to 0x40
    do_reset();
    clear_imem();
    imem[4]    = mk(OP_JUMP, 5'd1, 5'd2, 5'd0);
    imem[5]    = mk_li(5'd0, 22'h55);
    imem[9]    = mk(OP_HALT, 5'd0, 5'd0, 5'd0);
    imem[7'h40] = mk_li(5'd0, 22'h77);
    set_wb(1'b1, 5'd1, 32'd1);
    step();
    set_wb(1'b1, 5'd2, 32'h40);
    step();
    set_wb(1'b0, 5'd0, 32'd0);
    step();
    step();
    chk_eq("jmp_pc4", pc, 32'd4);
    step();
    chk_eq("jmp_squash", {31'd0, squash}, 32'd1);
    chk_eq("jmp_pc5", pc, 32'd5);
    step();
    chk_eq("jmp_target", pc, 32'h40);
    chk_eq("jmp_bubble", decode_ireg, 32'd0);
    chk_eq("jmp_sq_clr", {31'd0, squash}, 32'd0);
    step();
    chk_eq("jmp_pc41", pc, 32'h41);
    chk_eq("jmp_tgt_dec", decode_ireg, imem[7'h40]);
    step();
    chk_eq("jmp_tgt_alu", alu_result, 32'h77);

    // Same jump with r1 = 0 (cleared by reset): not taken, then HALT at pc 9
    do_reset();
    set_wb(1'b1, 5'd2, 32'h40);
    step();
    set_wb(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) step();
    chk_eq("njmp_squash", {31'd0, squash}, 32'd0);
    chk_eq("njmp_pc5", pc, 32'd5);
    step();
    chk_eq("njmp_pc6", pc, 32'd6);
    chk_eq("njmp_dec", decode_ireg, imem[5]);
    step();
    chk_eq("njmp_alu", alu_result, 32'h55);
    step();
    step();
    chk_eq("halt_pc9", pc, 32'd9);
    step();
    chk_eq("halt_hold1", pc, 32'd9);
    step();
    chk_eq("halt_hold2", pc, 32'd9);
    chk_eq("halt_dec", decode_ireg, imem[9]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
